// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - register file with pending-write scoreboard and sequential clear engine (optional trace: RF_TRACE_EN)
module rf_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic             rpend1,
    output logic             rpend2,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             clr,
    output logic             ready
);

    // Index width actually needed to address DEPTH entries; never wider than AW.
    localparam int             IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    ptr;
    logic [DEPTH-1:0] pend;
    logic [WIDTH-1:0] mem [DEPTH];

    logic wr_eff;
    logic rsv_eff;

    // An address is live when it exists and is not the hardwired zero entry.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_eff  = (state == ST_RUN) && we && addr_ok(waddr);
    assign rsv_eff = (state == ST_RUN) && rsv_en && addr_ok(rsv_addr);

    // Control FSM: sweep ptr through the array, then run; clr restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
        end else if (clr) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
        end else if (state == ST_CLEAR) begin
            if (ptr == LAST) begin
                state <= ST_RUN;
                ptr   <= '0;
                ready <= 1'b1;
            end else begin
                ptr <= ptr + AW'(1);
            end
        end
    end

    // Single write port shared by the clear engine and the normal write path.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[ptr[IW-1:0]] <= '0;
        end else if (wr_eff) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Scoreboard: a write retires the pending bit, a same-cycle reservation re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else if (clr) begin
            pend <= '0;
        end else if (state == ST_RUN) begin
            if (wr_eff) begin
                pend[waddr[IW-1:0]] <= 1'b0;
            end
            if (rsv_eff) begin
                pend[rsv_addr[IW-1:0]] <= 1'b1;
            end
        end
    end

    // Read ports with write-through bypass; everything reads as zero while clearing.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        rpend1 = 1'b0;
        rpend2 = 1'b0;
        if (state == ST_RUN) begin
            if (addr_ok(raddr1)) begin
                if (wr_eff && (waddr == raddr1)) begin
                    rdata1 = wdata;
                end else begin
                    rdata1 = mem[raddr1[IW-1:0]];
                end
                rpend1 = pend[raddr1[IW-1:0]] && !(wr_eff && (waddr == raddr1));
            end
            if (addr_ok(raddr2)) begin
                if (wr_eff && (waddr == raddr2)) begin
                    rdata2 = wdata;
                end else begin
                    rdata2 = mem[raddr2[IW-1:0]];
                end
                rpend2 = pend[raddr2[IW-1:0]] && !(wr_eff && (waddr == raddr2));
            end
        end
    end

`ifdef RF_TRACE_EN
    // Debug dump of the whole array, state and scoreboard on every falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 8 == 0) begin
                $write("%0d:", i);
            end
            $write(" %h", mem[i]);
            if ((i % 8 == 7) || (i == DEPTH - 1)) begin
                $write("\n");
            end
        end
        $display("----------------------------------------");
        $display("state=%s pend=%h", state.name(), pend);
    end
`endif

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - self-checking bench for rf_scoreboard (default and DEPTH=16/ZERO_REG=0 builds)
module tb_rf_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  raddr1, raddr2, waddr, rsv_addr;
    logic [31:0] wdata;
    logic        we, rsv_en, clr;

    logic [31:0] rdata1_a, rdata2_a, rdata1_b, rdata2_b;
    logic        rpend1_a, rpend2_a, rpend1_b, rpend2_b;
    logic        ready_a, ready_b;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: index 0 = default build, index 1 = DEPTH 16 / no zero register.
    logic [31:0] m_mem  [2][32];
    bit          m_pend [2][32];
    int          m_cl   [2];

    always #5 clk = ~clk;

    rf_scoreboard u_a (
        .clk(clk), .rst_n(rst_n),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_a), .rdata2(rdata2_a),
        .rpend1(rpend1_a), .rpend2(rpend2_a),
        .we(we), .waddr(waddr), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr(clr), .ready(ready_a)
    );

    rf_scoreboard #(.WIDTH(32), .DEPTH(16), .AW(5), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_b), .rdata2(rdata2_b),
        .rpend1(rpend1_b), .rpend2(rpend2_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clr(clr), .ready(ready_b)
    );

    function automatic int dep(int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic bit valid_addr(int k, logic [4:0] a);
        return (int'(a) < dep(k)) && !((k == 0) && (a == 5'd0));
    endfunction

    function automatic bit exp_ready(int k);
        return rst_n && (m_cl[k] == 0);
    endfunction

    function automatic bit m_wr(int k);
        return exp_ready(k) && we && valid_addr(k, waddr);
    endfunction

    function automatic logic [31:0] exp_data(int k, logic [4:0] a);
        if (!exp_ready(k) || !valid_addr(k, a)) return 32'h0;
        if (m_wr(k) && (waddr == a)) return wdata;
        return m_mem[k][a];
    endfunction

    function automatic logic exp_pend(int k, logic [4:0] a);
        if (!exp_ready(k) || !valid_addr(k, a)) return 1'b0;
        if (m_wr(k) && (waddr == a)) return 1'b0;
        return m_pend[k][a];
    endfunction

    // Starting a clear: contents are unobservable until the sweep ends, after which all are zero.
    task automatic model_reset(int k);
        m_cl[k] = dep(k);
        for (int i = 0; i < 32; i++) begin
            m_pend[k][i] = 1'b0;
            m_mem[k][i]  = 32'h0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clr) begin
                model_reset(k);
            end else if (m_cl[k] > 0) begin
                m_cl[k]--;
            end else begin
                if (m_wr(k)) begin
                    m_mem[k][waddr]  = wdata;
                    m_pend[k][waddr] = 1'b0;
                end
                if (rsv_en && valid_addr(k, rsv_addr)) m_pend[k][rsv_addr] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        #1;
        chk("ready_a",  32'(ready_a),  32'(exp_ready(0)));
        chk("ready_b",  32'(ready_b),  32'(exp_ready(1)));
        chk("rdata1_a", rdata1_a, exp_data(0, raddr1));
        chk("rdata2_a", rdata2_a, exp_data(0, raddr2));
        chk("rdata1_b", rdata1_b, exp_data(1, raddr1));
        chk("rdata2_b", rdata2_b, exp_data(1, raddr2));
        chk("rpend1_a", 32'(rpend1_a), 32'(exp_pend(0, raddr1)));
        chk("rpend2_a", 32'(rpend2_a), 32'(exp_pend(0, raddr2)));
        chk("rpend1_b", 32'(rpend1_b), 32'(exp_pend(1, raddr1)));
        chk("rpend2_b", 32'(rpend2_b), 32'(exp_pend(1, raddr2)));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        int nb;
        rst_n = 1'b0; we = 1'b0; rsv_en = 1'b0; clr = 1'b0;
        raddr1 = 5'd0; raddr2 = 5'd0; waddr = 5'd0; rsv_addr = 5'd0; wdata = 32'h0;
        model_reset(0);
        model_reset(1);

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            check_all();
            chk("rst_ready", 32'(ready_a), 32'h0);
            tick();
        end
        rst_n = 1'b1;

        // Initial clear: ready low for exactly DEPTH cycles
        n = 0; nb = 0;
        while (!ready_a && n < 100) begin
            raddr1 = 5'($urandom_range(0, 31));
            check_all();
            chk("clear_rdata1", rdata1_a, 32'h0);
            if (!ready_b) nb++;
            tick();
            n++;
        end
        chk("init_clear_len_a", 32'(n), 32'd32);
        chk("init_clear_len_b", 32'(nb), 32'd16);

        // Every address reads zero after the clear
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            check_all();
            chk("sweep0_a", rdata1_a, 32'h0);
            tick();
        end

        // Bypass then held value
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5;
        check_all();
        chk("bypass_same", rdata1_a, 32'hDEADBEEF);
        tick();
        we = 1'b0;
        check_all();
        chk("bypass_held", rdata1_a, 32'hDEADBEEF);

        // Zero register: write and reservation both ignored on the default build
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234; rsv_en = 1'b1; rsv_addr = 5'd0; raddr1 = 5'd0;
        check_all();
        chk("zero_rd_same", rdata1_a, 32'h0);
        chk("zero_pend_same", 32'(rpend1_a), 32'h0);
        tick();
        we = 1'b0; rsv_en = 1'b0;
        check_all();
        chk("zero_rd_next", rdata1_a, 32'h0);
        chk("zero_pend_next", 32'(rpend1_a), 32'h0);

        // Scoreboard on entry 7
        rsv_en = 1'b1; rsv_addr = 5'd7; raddr1 = 5'd7;
        check_all();
        tick();
        rsv_en = 1'b0;
        check_all();
        chk("rsv_visible", 32'(rpend1_a), 32'h1);
        we = 1'b1; waddr = 5'd7; wdata = 32'h55;
        check_all();
        chk("wr_clears_pend", 32'(rpend1_a), 32'h0);
        chk("wr_bypass_55", rdata1_a, 32'h55);
        tick();
        wdata = 32'h66; rsv_en = 1'b1;
        check_all();
        tick();
        we = 1'b0; rsv_en = 1'b0;
        check_all();
        chk("rsv_wins_pend", 32'(rpend1_a), 32'h1);
        chk("rsv_wins_data", rdata1_a, 32'h66);

        // Entry 0 is ordinary storage on the DEPTH=16 build; addr 20 does not exist there
        we = 1'b1; waddr = 5'd0; wdata = 32'hA5;
        tick();
        we = 1'b0; raddr1 = 5'd0;
        check_all();
        chk("b_addr0", rdata1_b, 32'hA5);
        we = 1'b1; waddr = 5'd20; wdata = 32'h77; raddr2 = 5'd20;
        check_all();
        chk("b_oob_bypass", rdata2_b, 32'h0);
        tick();
        we = 1'b0;
        check_all();
        chk("b_oob_read", rdata2_b, 32'h0);
        chk("a_addr20", rdata2_a, 32'h77);

        // Load regs 1..31 with some reservations, then clear
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = $urandom;
            rsv_en = (i % 3 == 0); rsv_addr = 5'(31 - i); raddr1 = 5'(i - 1);
            check_all();
            tick();
        end
        we = 1'b0; rsv_en = 1'b0;
        clr = 1'b1;
        check_all();
        tick();
        clr = 1'b0;
        n = 0; nb = 0;
        while (!ready_a && n < 100) begin
            we = (n == 5); waddr = 5'd3; wdata = 32'hBAD0BAD0; raddr1 = 5'd3;
            check_all();
            if (!ready_b) nb++;
            tick();
            n++;
        end
        we = 1'b0;
        chk("clr_len_a", 32'(n), 32'd32);
        chk("clr_len_b", 32'(nb), 32'd16);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(i);
            check_all();
            chk("post_clr_data", rdata1_a, 32'h0);
            chk("post_clr_pend", 32'(rpend1_a), 32'h0);
            tick();
        end

        // clr again ten cycles into a clear
        clr = 1'b1;
        check_all();
        tick();
        clr = 1'b0;
        n = 0;
        while (!ready_a && n < 200) begin
            clr = (n == 9);
            check_all();
            tick();
            n++;
        end
        clr = 1'b0;
        chk("double_clr_len", 32'(n), 32'd42);

        // Asynchronous reset in the middle of RUN
        we = 1'b1; waddr = 5'd9; wdata = 32'h9999; raddr1 = 5'd9;
        check_all();
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        check_all();
        chk("async_rst_ready", 32'(ready_a), 32'h0);
        chk("async_rst_data", rdata1_a, 32'h0);
        tick();
        rst_n = 1'b1; we = 1'b0;

        // Randomized traffic with occasional clr and reset pulses
        for (int c = 0; c < 600; c++) begin
            we       = ($urandom_range(0, 1) == 1);
            waddr    = 5'($urandom_range(0, 31));
            wdata    = $urandom;
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2   = ($urandom_range(0, 3) == 0) ? rsv_addr : 5'($urandom_range(0, 31));
            clr      = ($urandom_range(0, 99) == 0);
            rst_n    = ($urandom_range(0, 299) != 0);
            if (!rst_n) begin
                model_reset(0);
                model_reset(1);
            end
            check_all();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
